// File: rtl/timer_irq_ctrl.sv
// Periodic driver and interrupt collector for a one-shot timer: start pulses out, level IRQ to the host.
// Optional watchdog against a silent timer is compiled in with `define TIMER_IRQ_WATCHDOG_EN.
module timer_irq_ctrl #(
  parameter int TICK_WIDTH     = 16,
  parameter int OVR_WIDTH      = 8,
  parameter int WDOG_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  output logic                  timer_start_out,
  input  logic                  timer_int_in,
  input  logic                  ack_in,
  output logic                  irq_out,
  output logic                  busy_out,
  output logic [TICK_WIDTH-1:0] tick_count_out,
  output logic [OVR_WIDTH-1:0]  overrun_count_out,
  output logic                  timeout_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_WAIT} state_t;

  // The watchdog count must be able to hold the timeout value.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << WDOG_WIDTH)) begin : g_bad_cfg
    $error("timer_irq_ctrl: TIMEOUT_CYCLES does not fit in WDOG_WIDTH");
  end

  state_t state;
  logic   pending;
  logic   tick;
  logic   wdog_expire;

  // Interrupt pulses outside WAIT are stray and ignored.
  assign tick = (state == ST_WAIT) && timer_int_in;

`ifdef TIMER_IRQ_WATCHDOG_EN
  localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WDOG_WIDTH-1:0] wdog_cnt;
  logic                  timeout_q;

  // A tick in the expiry cycle wins, so the timeout needs the interrupt absent.
  assign wdog_expire = (state == ST_WAIT) && !timer_int_in && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_ARM)
        wdog_cnt <= '0;
      else if (state == ST_WAIT && !timer_int_in)
        wdog_cnt <= wdog_cnt + WDOG_WIDTH'(1);
      if (wdog_expire)
        timeout_q <= 1'b1;
    end
  end

  assign timeout_out = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state             <= ST_IDLE;
      pending           <= 1'b0;
      tick_count_out    <= '0;
      overrun_count_out <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (enable_in) state <= ST_ARM;
        ST_ARM:  state <= ST_WAIT;
        ST_WAIT: if (tick || wdog_expire) state <= enable_in ? ST_ARM : ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (tick) begin
        tick_count_out <= tick_count_out + TICK_WIDTH'(1);
        // An ack in the same cycle consumes the old interrupt, so nothing is lost.
        if (pending && !ack_in && overrun_count_out != '1)
          overrun_count_out <= overrun_count_out + OVR_WIDTH'(1);
        pending <= 1'b1;
      end else if (ack_in) begin
        pending <= 1'b0;
      end
    end
  end

  assign timer_start_out = (state == ST_ARM);
  assign busy_out        = (state != ST_IDLE);
  assign irq_out         = pending;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: 5-cycle one-shot timer model, TIMEOUT_CYCLES=20, event-level reference model.
// Watchdog expectations follow `define TIMER_IRQ_WATCHDOG_EN, matching the RTL build.
module tb_timer_irq_ctrl;
  localparam int TIMEOUT = 20;
  localparam int TIMER_COUNT = 5;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        enable_in;
  logic        timer_start_out;
  logic        timer_int_in;
  logic        ack_in;
  logic        irq_out;
  logic        busy_out;
  logic [15:0] tick_count_out;
  logic [7:0]  overrun_count_out;
  logic        timeout_out;

  int n_tests = 0;
  int n_fail  = 0;

  timer_irq_ctrl #(
    .TICK_WIDTH(16), .OVR_WIDTH(8), .WDOG_WIDTH(14), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock_in(clock_in), .reset_in(reset_in), .enable_in(enable_in),
    .timer_start_out(timer_start_out), .timer_int_in(timer_int_in), .ack_in(ack_in),
    .irq_out(irq_out), .busy_out(busy_out), .tick_count_out(tick_count_out),
    .overrun_count_out(overrun_count_out), .timeout_out(timeout_out)
  );

  always #5 clock_in = ~clock_in;

  // One-shot timer: a start seen while idle yields an interrupt pulse TIMER_COUNT cycles later.
  bit timer_en;
  int timer_cnt;
  always @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      timer_cnt    <= 0;
      timer_int_in <= 1'b0;
    end else begin
      timer_int_in <= 1'b0;
      if (timer_cnt != 0) begin
        timer_cnt <= timer_cnt - 1;
        if (timer_cnt == 1) timer_int_in <= 1'b1;
      end else if (timer_start_out && timer_en) begin
        timer_cnt <= TIMER_COUNT;
      end
    end
  end

  // Reference model: phase 0 = stopped, 1 = start cycle, 2 = waiting on the timer.
  int m_phase, m_wait_cyc, m_tick, m_ovr;
  bit m_pend, m_to, m_fired, m_expired;
  always @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      m_phase = 0; m_wait_cyc = 0; m_tick = 0; m_ovr = 0; m_pend = 0; m_to = 0;
    end else begin
      m_fired   = (m_phase == 2) && timer_int_in;
      m_expired = 0;
`ifdef TIMER_IRQ_WATCHDOG_EN
      if (m_phase == 2 && !m_fired) begin
        m_wait_cyc = m_wait_cyc + 1;
        if (m_wait_cyc >= TIMEOUT) m_expired = 1;
      end
`endif
      if (m_fired) begin
        m_tick = (m_tick + 1) % 65536;
        if (m_pend && !ack_in && m_ovr < 255) m_ovr = m_ovr + 1;
        m_pend = 1;
      end else if (ack_in) begin
        m_pend = 0;
      end
      if (m_expired) m_to = 1;
      case (m_phase)
        0: if (enable_in) m_phase = 1;
        1: begin m_phase = 2; m_wait_cyc = 0; end
        default: if (m_fired || m_expired) m_phase = enable_in ? 1 : 0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("start", 32'(timer_start_out), 32'(m_phase == 1));
    check("busy",  32'(busy_out),        32'(m_phase != 0));
    check("irq",   32'(irq_out),         32'(m_pend));
    check("tick",  32'(tick_count_out),  32'(m_tick));
    check("ovr",   32'(overrun_count_out), 32'(m_ovr));
    check("tmo",   32'(timeout_out),     32'(m_to));
  endtask

  // Advance n cycles, comparing against the model away from the active edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_in);
      compare_all();
    end
  endtask

  task automatic wait_tick(input string tag);
    logic [15:0] prev;
    int k;
    prev = tick_count_out;
    k = 0;
    while (k < 30 && tick_count_out == prev) begin step(1); k++; end
    check(tag, 32'(tick_count_out != prev), 32'd1);
  endtask

  initial begin
    int k;
    reset_in = 1'b1; enable_in = 1'b0; ack_in = 1'b0; timer_en = 1'b1;
    step(3);
    check("rst_start", 32'(timer_start_out), 32'd0);
    check("rst_busy",  32'(busy_out), 32'd0);
    check("rst_irq",   32'(irq_out), 32'd0);
    check("rst_tick",  32'(tick_count_out), 32'd0);
    check("rst_ovr",   32'(overrun_count_out), 32'd0);
    check("rst_tmo",   32'(timeout_out), 32'd0);
    reset_in = 1'b0;

    // Three acknowledged periods.
    enable_in = 1'b1;
    for (int p = 0; p < 3; p++) begin
      k = 0;
      while (k < 40 && !irq_out) begin step(1); k++; end
      check("p1_irq_seen", 32'(irq_out), 32'd1);
      step(2);
      ack_in = 1'b1; step(1); ack_in = 1'b0;
      check("p1_irq_acked", 32'(irq_out), 32'd0);
    end
    check("p1_tick", 32'(tick_count_out), 32'd3);
    check("p1_ovr",  32'(overrun_count_out), 32'd0);

    // Four unacknowledged periods: first sets pending, next three overrun.
    for (int p = 0; p < 4; p++) wait_tick("p2_tick_seen");
    check("p2_irq",  32'(irq_out), 32'd1);
    check("p2_tick", 32'(tick_count_out), 32'd7);
    check("p2_ovr",  32'(overrun_count_out), 32'd3);

    // Ack coinciding with the interrupt while pending.
    k = 0;
    while (k < 30 && !timer_int_in) begin step(1); k++; end
    check("p3_int_seen", 32'(timer_int_in), 32'd1);
    ack_in = 1'b1; step(1); ack_in = 1'b0;
    check("p3_irq",  32'(irq_out), 32'd1);
    check("p3_tick", 32'(tick_count_out), 32'd8);
    check("p3_ovr",  32'(overrun_count_out), 32'd3);

    // Drop enable in WAIT: period completes, then stop.
    k = 0;
    while (k < 30 && !timer_start_out) begin step(1); k++; end
    check("p4_start_seen", 32'(timer_start_out), 32'd1);
    step(1);
    enable_in = 1'b0;
    wait_tick("p4_tick_seen");
    step(10);
    check("p4_busy",  32'(busy_out), 32'd0);
    check("p4_start", 32'(timer_start_out), 32'd0);
    check("p4_tick",  32'(tick_count_out), 32'd9);
    ack_in = 1'b1; step(1); ack_in = 1'b0;
    check("p4_irq", 32'(irq_out), 32'd0);

    // Random enable and ack traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) enable_in = ~enable_in;
      ack_in = ($urandom_range(0, 3) == 0);
      step(1);
    end
    ack_in = 1'b0;

    // Asynchronous reset while waiting with an interrupt pending.
    enable_in = 1'b1;
    k = 0;
    while (k < 40 && !irq_out) begin step(1); k++; end
    check("p6_irq_seen", 32'(irq_out), 32'd1);
    k = 0;
    while (k < 30 && !timer_start_out) begin step(1); k++; end
    step(2);
    check("p6_in_wait", 32'(busy_out && !timer_start_out), 32'd1);
    #2 reset_in = 1'b1;
    #1;
    check("p6_rst_start", 32'(timer_start_out), 32'd0);
    check("p6_rst_busy",  32'(busy_out), 32'd0);
    check("p6_rst_irq",   32'(irq_out), 32'd0);
    check("p6_rst_tick",  32'(tick_count_out), 32'd0);
    check("p6_rst_ovr",   32'(overrun_count_out), 32'd0);
    check("p6_rst_tmo",   32'(timeout_out), 32'd0);
    step(1);
    reset_in = 1'b0;
    wait_tick("p6_resume_tick");
    check("p6_resume_cnt", 32'(tick_count_out), 32'd1);
    check("p6_resume_irq", 32'(irq_out), 32'd1);

    // Silent timer.
    reset_in = 1'b1; timer_en = 1'b0;
    step(2);
    reset_in = 1'b0;
    k = 0;
    while (k < 10 && !timer_start_out) begin step(1); k++; end
    check("p7_start_seen", 32'(timer_start_out), 32'd1);
`ifdef TIMER_IRQ_WATCHDOG_EN
    k = 0;
    while (k < 40 && !timeout_out) begin step(1); k++; end
    check("p7_tmo",        32'(timeout_out), 32'd1);
    check("p7_tmo_cycles", 32'(k), 32'(TIMEOUT + 1));
    check("p7_rearm",      32'(timer_start_out), 32'd1);
    check("p7_tick",       32'(tick_count_out), 32'd0);
    step(TIMEOUT + 5);
    check("p7_tmo_sticky", 32'(timeout_out), 32'd1);
`else
    step(2 * TIMEOUT);
    check("p7_tmo",  32'(timeout_out), 32'd0);
    check("p7_busy", 32'(busy_out), 32'd1);
    check("p7_tick", 32'(tick_count_out), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
